// File: rtl/video_test_pattern.sv
// video_test_pattern: registered four-mode test-pattern generator (checker, bars, gradient, bouncing square)
// with a debounced mode button and per-frame animation state.
module video_test_pattern #(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int CELL_LOG2 = 3,
  parameter int SQUARE_SIZE = 32,
  parameter int DEBOUNCE_CYCLES = 250000,
  localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
  localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [X_WIDTH-1:0] x,
  input  logic [Y_WIDTH-1:0] y,
  input  logic               frame_start,
  input  logic               btn,
  output logic [7:0]         r,
  output logic [7:0]         g,
  output logic [7:0]         b
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [X_WIDTH-1:0] X_MAX = X_WIDTH'(HOR_ACTIVE_PIXELS - SQUARE_SIZE);
  localparam logic [Y_WIDTH-1:0] Y_MAX = Y_WIDTH'(VER_ACTIVE_PIXELS - SQUARE_SIZE);
  logic btn_meta, btn_sync, btn_stable, btn_stable_d;
  logic [CW-1:0] db_cnt;
  logic [1:0] mode;
  logic [7:0] frame_cnt;
  logic [X_WIDTH-1:0] sq_x;
  logic [Y_WIDTH-1:0] sq_y;
  logic dx_neg, dy_neg, dx_nxt, dy_nxt;
  logic [2:0] bar;
  logic chk, in_sq;
  logic [7:0] pr, pg, pb;
  always_ff @(posedge clk)
    if (!rst_n) begin
      {btn_meta, btn_sync, btn_stable, btn_stable_d} <= '0;
      db_cnt <= '0;
      mode <= '0;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
      btn_stable_d <= btn_stable;
      if (btn_sync == btn_stable) db_cnt <= '0;
      else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        btn_stable <= btn_sync;
        db_cnt <= '0;
      end else db_cnt <= db_cnt + 1'b1;
      if (btn_stable && !btn_stable_d) mode <= mode + 2'd1;
    end
  // Direction for this step: reverse at the edge, then move one pixel that way.
  assign dx_nxt = dx_neg ? (sq_x != '0) : (sq_x == X_MAX);
  assign dy_nxt = dy_neg ? (sq_y != '0) : (sq_y == Y_MAX);
  always_ff @(posedge clk)
    if (!rst_n) begin
      frame_cnt <= '0;
      sq_x <= '0;
      sq_y <= '0;
      dx_neg <= 1'b0;
      dy_neg <= 1'b0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + 8'd1;
      dx_neg <= dx_nxt;
      dy_neg <= dy_nxt;
      sq_x <= dx_nxt ? sq_x - 1'b1 : sq_x + 1'b1;
      sq_y <= dy_nxt ? sq_y - 1'b1 : sq_y + 1'b1;
    end
  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++)
      if (int'({x, 3'b000}) >= k * HOR_ACTIVE_PIXELS) bar = bar + 3'd1;
    chk = x[CELL_LOG2] ^ y[CELL_LOG2];
    in_sq = int'(x) >= int'(sq_x) && int'(x) < int'(sq_x) + SQUARE_SIZE &&
            int'(y) >= int'(sq_y) && int'(y) < int'(sq_y) + SQUARE_SIZE;
    pr = mode == 2'd0 ? {8{chk}} : mode == 2'd1 ? {8{~bar[1]}} : mode == 2'd2 ? 8'(x) : {8{in_sq}};
    pg = mode == 2'd0 ? {8{chk}} : mode == 2'd1 ? {8{~bar[2]}} : mode == 2'd2 ? 8'(y) : {8{in_sq}};
    pb = mode == 2'd0 ? {8{chk}} : mode == 2'd1 ? {8{~bar[0]}} : mode == 2'd2 ? frame_cnt : {8{in_sq}};
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      r <= '0;
      g <= '0;
      b <= '0;
    end else begin
      r <= pr;
      g <= pg;
      b <= pb;
    end
endmodule

// File: tb/tb_video_test_pattern.sv
// tb_video_test_pattern: randomized scoreboard bench; expected pixels come from a frame-count based model.
module tb_video_test_pattern;
  localparam int H = 640, V = 480, SQ = 32, DB = 16;
  localparam logic [23:0] BARS [8] = '{24'hffffff, 24'hffff00, 24'h00ffff, 24'h00ff00,
                                       24'hff00ff, 24'hff0000, 24'h0000ff, 24'h000000};
  logic clk = 0, rst_n = 0, frame_start = 0, btn = 0;
  logic [9:0] x = 0;
  logic [8:0] y = 0;
  logic [7:0] r, g, b;
  logic issue = 0, vld_d = 0;
  logic [23:0] exp_q[$];
  string name_q[$];
  int n_tests = 0, n_fail = 0;
  int nf = 0, mode_m = 0;

  video_test_pattern #(.HOR_ACTIVE_PIXELS(H), .VER_ACTIVE_PIXELS(V), .CELL_LOG2(3),
                       .SQUARE_SIZE(SQ), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .frame_start(frame_start),
    .btn(btn), .r(r), .g(g), .b(b));

  always #5 clk = ~clk;
  always @(posedge clk) vld_d <= issue;

  // Square position is a triangle wave of the frame count with period 2*(extent-size).
  function automatic int tri_pos(int n, int l);
    int m = n % (2 * l);
    return m <= l ? m : 2 * l - m;
  endfunction

  function automatic logic [23:0] model(int px, int py);
    int sx = tri_pos(nf, H - SQ);
    int sy = tri_pos(nf, V - SQ);
    case (mode_m)
      0: return ((px / 8 + py / 8) % 2) != 0 ? 24'hffffff : 24'h000000;
      1: return BARS[px >= H ? 7 : px * 8 / H];
      2: return {8'(px % 256), 8'(py % 256), 8'(nf % 256)};
      default: return (px >= sx && px < sx + SQ && py >= sy && py < sy + SQ) ? 24'hffffff : 24'h000000;
    endcase
  endfunction

  always @(negedge clk)
    if (vld_d) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got %h with no expectation queued", {r, g, b});
      end else begin
        logic [23:0] e;
        string nm;
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        if ({r, g, b} !== e) begin
          n_fail++;
          $display("FAIL %s: got rgb=%h expected %h", nm, {r, g, b}, e);
        end
      end
    end

  task automatic pix(int px, int py, string nm);
    @(negedge clk);
    x = 10'(px);
    y = 9'(py);
    issue = 1;
    exp_q.push_back(model(px, py));
    name_q.push_back(nm);
    @(negedge clk);
    issue = 0;
  endtask

  task automatic rand_pix(int n, int cx, int cy, int span, string nm);
    repeat (n) begin
      int px, py;
      px = span == 0 ? int'($urandom_range(1023)) : cx + int'($urandom_range(2 * span)) - span;
      py = span == 0 ? int'($urandom_range(511)) : cy + int'($urandom_range(2 * span)) - span;
      px = px < 0 ? 0 : px > 1023 ? 1023 : px;
      py = py < 0 ? 0 : py > 511 ? 511 : py;
      pix(px, py, nm);
    end
  endtask

  task automatic frames(int n);
    repeat (n) begin
      @(negedge clk);
      frame_start = 1;
      nf++;
      @(negedge clk);
      frame_start = 0;
    end
  endtask

  // A hold long enough to pass the synchroniser and debounce window advances the mode.
  task automatic press(int hold, bit with_frames);
    @(negedge clk);
    btn = 1;
    repeat (hold) begin
      @(negedge clk);
      if (with_frames) begin
        frame_start = 1;
        nf++;
      end
    end
    @(negedge clk);
    frame_start = 0;
    btn = 0;
    repeat (DB + 8) @(negedge clk);
    if (hold >= DB + 8) mode_m = (mode_m + 1) % 4;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    btn = 1;
    @(negedge clk);
    frame_start = 1;
    @(negedge clk);
    frame_start = 0;
    btn = 0;
    rst_n = 1;
    n_tests++;
    if ({r, g, b} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_rgb: got %h expected 000000", {r, g, b});
    end
    pix(8, 0, "chk_8_0");
    pix(8, 8, "chk_8_8");
    pix(7, 0, "chk_7_0");
    rand_pix(15, 0, 0, 0, "chk_rand");
    press(10, 0);
    pix(8, 0, "glitch_keeps_mode0");
    press(DB + 8, 0);
    pix(80, 0, "bar_80");
    pix(639, 0, "bar_639");
    pix(700, 3, "bar_clamp");
    rand_pix(15, 0, 0, 0, "bar_rand");
    press(DB + 8, 1);
    rand_pix(10, 0, 0, 0, "grad_rand");
    frames(300 - nf);
    pix(300, 200, "grad_300");
    press(DB + 8, 0);
    frames(448 - nf);
    pix(448, 448, "sq448_in");
    pix(480, 448, "sq448_right");
    pix(447, 448, "sq448_left");
    frames(608 - nf);
    pix(608, 288, "sq608_in");
    pix(640, 288, "sq608_right");
    frames(1);
    pix(607, 287, "sq609_in");
    pix(639, 287, "sq609_right");
    pix(638, 318, "sq609_corner");
    rand_pix(15, 620, 300, 40, "sq_rand");
    press(DB + 8, 0);
    pix(8, 0, "wrap_mode0");
    @(negedge clk);
    btn = 1;
    repeat (12) @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    nf = 0;
    mode_m = 0;
    repeat (12) @(negedge clk);
    btn = 0;
    repeat (DB + 8) @(negedge clk);
    pix(8, 0, "midreset_mode0");
    press(DB + 8, 0);
    press(DB + 8, 0);
    press(DB + 8, 0);
    pix(0, 0, "midreset_sq_in");
    pix(32, 0, "midreset_sq_out");
    pix(31, 31, "midreset_sq_corner");
    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
